// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } ps2_state_e;

    // Odd parity over the data byte and its parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// First-word fall-through FIFO; head is read combinationally from storage.
module ps2_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when the head leaves in the same
    // cycle; the tail slot then coincides with the head being vacated.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes and checks
// each 11-bit frame, and queues accepted scan codes behind a valid/ready port.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned SW = PS2_FRAME_BITS - 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   fall_q;
    logic                   bit_q;

    ps2_state_e             state_q, state_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [SW-1:0]          shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    logic                   push;
    logic                   overflow_q;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Synchronisers, edge history and a registered falling-edge strobe with
    // its matching data sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            clk_sync_q[0]  <= ps2_clk;
            data_sync_q[0] <= ps2_data;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i]  <= clk_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            fall_q     <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            bit_q      <= data_sync_q[SYNC_STAGES-1];
        end
    end

    // Frame FSM state, bit counter, shift register and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tmo_q    <= tmo_d;
        end
    end

    // Frame FSM next-state, push request and error pulse.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                if (fall_q && !bit_q) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall_q) begin
                    shift_d  = {bit_q, shift_q[SW-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    bitcnt_d  = '0;
                    frame_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                state_d  = IDLE;
                bitcnt_d = '0;
                // shift_q holds d0..d7 in [7:0], parity in [8], stop in [9].
                if (shift_q[9] && parity_ok(shift_q[7:0], shift_q[8])) begin
                    push = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow: a good frame found the FIFO full with no pop to make room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !ready) begin
            overflow_q <= 1'b1;
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push),
        .wr_data_i (shift_q[7:0]),
        .pop_i     (ready),
        .rd_data_o (data_out),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign valid    = ~fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx against a frame-level queue model.
module tb_ps2_keyboard_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 300;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned HALF  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         exp_bad = 0;
    int         err_seen = 0;
    int unsigned cyc = 0;
    int unsigned last_fall_cyc = 0;
    int unsigned last_err_cyc = 0;
    int         lat = 0;
    logic [7:0] last_pop = 8'h00;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Error-pulse counter and pop checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_seen++;
            last_err_cyc = cyc;
        end
        if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                last_pop = exp_q.pop_front();
                check_eq("pop_data", 32'(data_out), 32'(last_pop));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Drives one frame (or its first nbits bits) and updates the model at the
    // stop-bit falling edge.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                              input int nbits, input logic pop_in_check);
        logic [10:0] b;
        logic        good;
        b[0]    = 1'b0;
        b[8:1]  = d;
        b[9]    = (~^d) ^ par_flip;
        b[10]   = stop_bit;
        lat     = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = b[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) begin
                good = b[10] && (^b[9:1]);
                if (good) begin
                    if (exp_q.size() < DEPTH || pop_in_check) exp_q.push_back(d);
                    else exp_ovf = 1'b1;
                end else begin
                    exp_bad++;
                end
            end
            for (int k = 1; k <= int'(HALF); k++) begin
                @(posedge clk);
                #1;
                if (i == 10 && lat == 0 && valid === 1'b1) lat = k;
                if (i == 10 && pop_in_check) ready = (k == int'(SYNC) + 2);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input logic random_ready);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b1) break;
            ready = random_ready ? 1'($urandom % 2) : 1'b1;
        end
        ready = 1'b0;
        @(negedge clk);
        check_eq("drain_valid", 32'(valid), 32'd0);
        check_eq("drain_count", 32'(fifo_count), 32'd0);
        check_eq("drain_model", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check_eq({tag, "_err"}, 32'(err_seen), 32'(exp_bad));
        if (exp_q.size() > 0) check_eq({tag, "_head"}, 32'(data_out), 32'(exp_q[0]));
        else check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int n;
        logic in_win;
        int unsigned delta;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        ready = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'h00);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_err", 32'(frame_err), 32'd0);

        // Single frame, latency, single pop
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check_eq("lat", 32'(lat), 32'(SYNC + 3));
        check_eq("f1_data", 32'(data_out), 32'h1C);
        check_eq("f1_valid", 32'(valid), 32'd1);
        check_eq("f1_count", 32'(fifo_count), 32'd1);
        @(posedge clk); #1; ready = 1'b1;
        @(posedge clk); #1; ready = 1'b0;
        check_eq("f1_pop_valid", 32'(valid), 32'd0);
        check_eq("f1_pop_count", 32'(fifo_count), 32'd0);

        // Streaming with ready held high
        @(posedge clk); #1; ready = 1'b1;
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        @(posedge clk); #1; ready = 1'b0;
        @(negedge clk);
        check_eq("stream_last", 32'(last_pop), 32'h1C);
        check_state("stream");

        // Bad parity, then bad stop
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        check_state("badpar");
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check_state("badstop");

        // Overflow: nine frames with no consumer
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0);
        check_state("ovf");
        check_eq("ovf_head", 32'(data_out), 32'h01);
        drain(1'b0);
        check_eq("ovf_last", 32'(last_pop), 32'h08);

        // Full FIFO with a pop in the CHECK cycle
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 11, 1'b1);
        check_state("fullpop");
        check_eq("fullpop_ovf0", 32'(overflow), 32'd0);
        drain(1'b0);
        check_eq("fullpop_last", 32'(last_pop), 32'h55);

        // Timeout on a partial frame, then recovery
        exp_bad++;
        send_frame(8'h2A, 1'b0, 1'b1, 5, 1'b0);
        repeat (TMO + 40) @(negedge clk);
        delta  = last_err_cyc - last_fall_cyc;
        in_win = (last_err_cyc > last_fall_cyc) && (delta >= TMO) && (delta <= TMO + SYNC + 4);
        check_eq("tmo_window", 32'(in_win), 32'd1);
        check_state("tmo");
        send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0);
        check_state("tmo_next");
        drain(1'b0);

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b0, 1'b1, 6, 1'b0);
        do_reset();
        check_eq("mrst_valid", 32'(valid), 32'd0);
        check_eq("mrst_data", 32'(data_out), 32'h00);
        check_state("mrst");
        send_frame(8'h3B, 1'b0, 1'b1, 11, 1'b0);
        check_state("mrst_next");
        drain(1'b0);

        // Randomized rounds: random codes and corruption, then random drain
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 11));
            for (int i = 0; i < n; i++) begin
                send_frame(8'($urandom), 1'(($urandom % 4) == 0), 1'(($urandom % 5) != 0), 11, 1'b0);
            end
            check_state("rand");
            drain(1'b1);
            check_state("rand_end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
